// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache miss refill FSM, critical-word-first wrapping burst
// Optional critical-word forward port enabled by defining ICACHE_REFILL_FWD_EN.
module icache_refill #(
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [31:0] i_addr,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_mreq,
    output logic [31:0] o_maddr,
    input  logic        i_mack,
    input  logic [31:0] i_mdata,
    output logic        o_wen,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata
`ifdef ICACHE_REFILL_FWD_EN
    ,
    output logic        o_fwd_valid,
    output logic [31:0] o_fwd_data
`endif
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);
    localparam logic [31:0] BLK_MASK = 32'(BURST * 4 - 1);

    typedef enum logic [1:0] {IDLE, REQ, WR} state_t;

    state_t         state, state_nxt;
    logic [31:0]    base_addr;
    logic [31:0]    cur_addr;
    logic [31:0]    cap_addr;
    logic [31:0]    cap_data;
    logic [CW-1:0]  count;
    logic           abort_pend;
    logic           load;
    logic           capture;
    logic           advance;
    logic [31:0]    next_addr;

    // Offset within the aligned block wraps; upper bits come from the miss address.
    assign next_addr = (base_addr & ~BLK_MASK) | ((cur_addr + 32'd4) & BLK_MASK);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (i_miss && !i_abort) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                // An ack in the abort cycle still delivers its word.
                if (i_mack) begin
                    state_nxt = WR;
                    capture   = 1'b1;
                end else if (i_abort) begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                if (abort_pend || i_abort || count == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REQ;
                    advance   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_addr  <= 32'd0;
            cur_addr   <= 32'd0;
            cap_addr   <= 32'd0;
            cap_data   <= 32'd0;
            count      <= '0;
            abort_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                base_addr  <= i_addr & ~32'd3;
                cur_addr   <= i_addr & ~32'd3;
                count      <= '0;
                abort_pend <= 1'b0;
            end
            if (capture) begin
                cap_addr   <= cur_addr;
                cap_data   <= i_mdata;
                abort_pend <= i_abort;
            end
            if (advance) begin
                count    <= count + CW'(1);
                cur_addr <= next_addr;
            end
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_mreq  = (state == REQ);
    assign o_maddr = cur_addr;
    assign o_wen   = (state == WR);
    assign o_waddr = cap_addr;
    assign o_wdata = cap_data;

`ifdef ICACHE_REFILL_FWD_EN
    assign o_fwd_valid = (state == WR) && (count == '0);
    assign o_fwd_data  = cap_data;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill (BURST=4)
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_abort = 1'b0;
    logic        i_mack = 1'b1;
    logic [31:0] i_mdata;
    logic        o_busy, o_mreq, o_wen;
    logic [31:0] o_maddr, o_waddr, o_wdata;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_data = 32'd0;
`ifdef ICACHE_REFILL_FWD_EN
    logic        o_fwd_valid;
    logic [31:0] o_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: each word's data is a fixed pattern of its address.
    assign i_mdata = use_fixed ? fixed_data : (32'hC0DE_0000 ^ o_maddr);

    icache_refill #(.BURST(4)) dut (
        .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .i_abort(i_abort),
        .o_busy(o_busy), .o_mreq(o_mreq), .o_maddr(o_maddr), .i_mack(i_mack),
        .i_mdata(i_mdata), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata)
`ifdef ICACHE_REFILL_FWD_EN
        , .o_fwd_valid(o_fwd_valid), .o_fwd_data(o_fwd_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        i_miss = 1'b0; i_abort = 1'b0; i_mack = 1'b1; use_fixed = 1'b0;
        repeat (12) tick();
    endtask

    task automatic start_miss(input logic [31:0] a);
        i_miss = 1'b1;
        i_addr = a;
        tick();
        i_miss = 1'b0;
        i_addr = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_miss = 1'b1; i_addr = 32'h0000_1234; i_mack = 1'b1; i_abort = 1'b1;
        tick(); tick();
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {o_busy, o_mreq, o_wen});
        end
        checks++;
        if ({o_maddr, o_waddr, o_wdata} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h exp 0", o_maddr, o_waddr, o_wdata);
        end
        i_miss = 1'b0; i_abort = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy got %b exp 0", o_busy);
        end
    endtask

    task automatic test_burst();
        logic [31:0] exp_addr [4];
        int k;
        exp_addr = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        start_miss(32'h0000_100A);
        for (int c = 1; c <= 8; c++) begin
            if (c % 2 == 1) begin
                k = (c - 1) / 2;
                checks++;
                if ({o_busy, o_mreq, o_wen} !== 3'b110 || o_maddr !== exp_addr[k]) begin
                    errors++;
                    $display("FAIL burst_req c%0d got %b %h exp 110 %h", c, {o_busy, o_mreq, o_wen}, o_maddr, exp_addr[k]);
                end
            end else begin
                k = (c - 2) / 2;
                checks++;
                if ({o_busy, o_mreq, o_wen} !== 3'b101 || o_waddr !== exp_addr[k] ||
                    o_wdata !== (32'hC0DE_0000 ^ exp_addr[k])) begin
                    errors++;
                    $display("FAIL burst_wr c%0d got %b %h %h exp 101 %h %h", c, {o_busy, o_mreq, o_wen},
                             o_waddr, o_wdata, exp_addr[k], 32'hC0DE_0000 ^ exp_addr[k]);
                end
            end
            tick();
        end
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b000) begin
            errors++; $display("FAIL burst_done_c9 got %b exp 000", {o_busy, o_mreq, o_wen});
        end
    endtask

    task automatic test_mack_delay();
        int nw;
        start_miss(32'h0000_1008);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({o_busy, o_mreq, o_wen} !== 3'b110 || o_maddr !== 32'h100C) begin
                errors++;
                $display("FAIL delay_hold i%0d got %b %h exp 110 0000100c", i, {o_busy, o_mreq, o_wen}, o_maddr);
            end
            i_mack = (i == 3);
            tick();
        end
        checks++;
        if (o_wen !== 1'b1 || o_waddr !== 32'h100C || o_wdata !== 32'hC0DE_100C) begin
            errors++; $display("FAIL delay_wr got %b %h %h exp 1 0000100c c0de100c", o_wen, o_waddr, o_wdata);
        end
        nw = 0;
        for (int i = 0; i < 20 && o_busy; i++) begin
            tick();
            if (o_wen) nw++;
        end
        checks++;
        if (o_busy !== 1'b0 || nw != 2) begin
            errors++; $display("FAIL delay_tail got busy %b wens %0d exp 0 2", o_busy, nw);
        end
    endtask

    task automatic test_abort();
        int n;
        start_miss(32'h0000_1008);
        tick(); tick();
        checks++;
        if (o_mreq !== 1'b1 || o_maddr !== 32'h100C) begin
            errors++; $display("FAIL abort_pre got %b %h exp 1 0000100c", o_mreq, o_maddr);
        end
        i_mack = 1'b0; i_abort = 1'b1;
        tick();
        i_mack = 1'b1; i_abort = 1'b0;
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b000) begin
            errors++; $display("FAIL abort_noack got %b exp 000", {o_busy, o_mreq, o_wen});
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_wen || o_mreq) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL abort_noack_quiet got %0d exp 0", n);
        end

        start_miss(32'h0000_1008);
        tick(); tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b101 || o_waddr !== 32'h100C) begin
            errors++; $display("FAIL abort_ack_wr got %b %h exp 101 0000100c", {o_busy, o_mreq, o_wen}, o_waddr);
        end
        tick();
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b000) begin
            errors++; $display("FAIL abort_ack_idle got %b exp 000", {o_busy, o_mreq, o_wen});
        end

        start_miss(32'h0000_1008);
        tick();
        i_abort = 1'b1;
        checks++;
        if (o_wen !== 1'b1 || o_waddr !== 32'h1008) begin
            errors++; $display("FAIL abort_in_wr got %b %h exp 1 00001008", o_wen, o_waddr);
        end
        tick();
        i_abort = 1'b0;
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b000) begin
            errors++; $display("FAIL abort_in_wr_idle got %b exp 000", {o_busy, o_mreq, o_wen});
        end
    endtask

    task automatic test_rst_mid();
        int n;
        start_miss(32'h0000_1008);
        tick();
        checks++;
        if (o_wen !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre got %b exp 1", o_wen);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({o_busy, o_mreq, o_wen} !== 3'b000 || {o_maddr, o_waddr, o_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL rst_mid_zero got %b %h %h %h exp all 0", {o_busy, o_mreq, o_wen}, o_maddr, o_waddr, o_wdata);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_wen || o_mreq) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL rst_mid_quiet got %0d exp 0", n);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [4];
        logic [31:0] got [4];
        int n, nw;
        exp_addr = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        got = '{32'd0, 32'd0, 32'd0, 32'd0};
        n = 0; nw = 0;
        start_miss(32'h0000_1008);
        for (int c = 1; c <= 8; c++) begin
            if (o_mreq && n < 4) begin
                got[n] = o_maddr;
                n++;
            end
            if (o_wen) nw++;
            i_miss = (c >= 2 && c <= 4);
            i_addr = i_miss ? 32'h2000 : 32'd0;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== exp_addr[k]) begin
                errors++; $display("FAIL ignore_miss_addr%0d got %h exp %h", k, got[k], exp_addr[k]);
            end
        end
        checks++;
        if (nw != 4 || o_busy !== 1'b0) begin
            errors++; $display("FAIL ignore_miss_end got wens %0d busy %b exp 4 0", nw, o_busy);
        end
        start_miss(32'h0000_2000);
        checks++;
        if (o_mreq !== 1'b1 || o_maddr !== 32'h2000) begin
            errors++; $display("FAIL back_to_back got %b %h exp 1 00002000", o_mreq, o_maddr);
        end
    endtask

`ifdef ICACHE_REFILL_FWD_EN
    task automatic test_fwd();
        int n;
        use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
        start_miss(32'h0000_1008);
        checks++;
        if (o_fwd_valid !== 1'b0) begin
            errors++; $display("FAIL fwd_early got %b exp 0", o_fwd_valid);
        end
        tick();
        checks++;
        if (o_fwd_valid !== 1'b1 || o_wen !== 1'b1 || o_fwd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fwd_first got %b %b %h exp 1 1 deadbeef", o_fwd_valid, o_wen, o_fwd_data);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_fwd_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL fwd_later got %0d exp 0", n);
        end
        use_fixed = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        settle();
        test_burst();
        settle();
        test_mack_delay();
        settle();
        test_abort();
        settle();
        test_rst_mid();
        settle();
        test_back_to_back();
        settle();
`ifdef ICACHE_REFILL_FWD_EN
        test_fwd();
        settle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter BURST, default 4, meaning words fetched per miss; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_miss  input  1  fetch-stage miss pulse (instruction cache hit low on valid fetch).
REQ-005 SHALL have port i_addr  input  32  missing fetch address, sampled with i_miss.
REQ-006 SHALL have port i_abort  input  1  cancel refill (branch redirect or flush).
REQ-007 SHALL have port o_busy  output  1  refill in progress; fetch stalls while high.
REQ-008 SHALL have port o_mreq  output  1  memory read request.
REQ-009 SHALL have port o_maddr  output  32  memory read word address, bits [1:0] always 0.
REQ-010 SHALL have port i_mack  input  1  memory accepts request and returns data the same cycle.
REQ-011 SHALL have port i_mdata  input  32  memory read data, valid when i_mack high.
REQ-012 SHALL have ports o_wen (output, 1), o_waddr (output, 32), o_wdata (output, 32), the instruction cache fill write port.

Function
REQ-013 SHALL implement states IDLE, REQ, WR.
REQ-014 SHALL, in IDLE with i_miss high and i_abort low, latch i_addr with [1:0] forced 0 as base and current address, clear word count, enter REQ next cycle.
REQ-015 SHALL ignore i_miss while not in IDLE.
REQ-016 SHALL, in REQ, drive o_mreq=1 and o_maddr=current address, holding both stable until i_mack.
REQ-017 SHALL, in REQ with i_mack high, capture i_mdata and current address and enter WR.
REQ-018 SHALL, in WR, drive o_wen=1 for exactly one cycle with o_waddr and o_wdata from captured values.
REQ-019 SHALL, leaving WR, return to IDLE if count equals BURST-1, else increment count, advance current address, and re-enter REQ.
REQ-020 SHALL advance address by 4, wrapping within the BURST*4-byte aligned block of base (critical-word-first): bits [log2(BURST)+1:2] increment modulo BURST, upper bits unchanged.
REQ-021 SHALL, with BURST=1, perform one REQ/WR then return to IDLE.
REQ-022 SHALL, with i_abort in REQ and i_mack low, go to IDLE next cycle, no write.
REQ-023 SHALL, with i_abort in REQ and i_mack high, complete that word's WR then go to IDLE.
REQ-024 SHALL, with i_abort in WR, still assert o_wen that cycle, then go to IDLE.
REQ-025 SHALL drive o_busy high in REQ and WR, low in IDLE.
REQ-026 SHALL give minimum latency i_miss (cycle 0) -> o_mreq (cycle 1) -> o_wen (cycle 2) with i_mack tied high; full burst of BURST words in 2*BURST+1 cycles.

Reset
REQ-027 SHALL, on rst high at a clock edge, enter IDLE and zero count, addresses and captured data, overriding any pending i_miss, i_mack or i_abort.
REQ-028 SHALL reset o_busy, o_mreq, o_wen to 0 and o_maddr, o_waddr, o_wdata to 0.
REQ-029 SHALL, with rst asserted mid-burst, issue no further o_mreq or o_wen after the reset edge.

Configuration
REQ-030 SHALL, with macro ICACHE_REFILL_FWD_EN defined, add outputs o_fwd_valid (1) and o_fwd_data (32), asserting o_fwd_valid for one cycle alongside o_wen of the first (critical) word with o_fwd_data equal to that word, and never for later words.
REQ-031 SHALL, without ICACHE_REFILL_FWD_EN, omit o_fwd_valid and o_fwd_data entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: BURST=4, i_miss with i_addr=0x0000_1008, i_mack tied 1 -> o_maddr 0x1008, 0x100C, 0x1000, 0x1004; four o_wen pulses; o_busy low at cycle 9.
REQ-033 SHALL cover: i_mack delayed 3 cycles on second word -> o_mreq and o_maddr held stable, no o_wen until ack.
REQ-034 SHALL cover: i_abort in REQ of word 2 with i_mack low -> no further o_wen, o_busy low next cycle; i_abort with i_mack high -> that word still written.
REQ-035 SHALL cover: rst pulsed during WR of word 1 -> all outputs 0 next cycle, no later o_mreq.
REQ-036 SHALL cover: second i_miss (i_addr=0x2000) during burst -> ignored; only the original block filled.
REQ-037 SHALL cover: ICACHE_REFILL_FWD_EN defined, i_miss at 0x1008 with i_mdata=0xDEAD_BEEF -> o_fwd_valid one cycle with o_fwd_data 0xDEAD_BEEF, coincident with first o_wen.
